// File: rtl/cdc_fifo_pkg.sv
// rtl/cdc_fifo_pkg.sv - register map, bit positions and CTRL layout for cdc_fifo_mmio
package cdc_fifo_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int DATA_VALID_BIT = 8;

    localparam int ST_RX_EMPTY = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_TX_FULL  = 3;
    localparam int ST_TX_DROP  = 4;
    localparam int ST_RX_CNT   = 8;
    localparam int ST_TX_CNT   = 16;

    localparam int CT_RX_IRQ_EN = 0;
    localparam int CT_TX_IRQ_EN = 1;
    localparam int CT_RX_FLUSH  = 2;
    localparam int CT_TX_FLUSH  = 3;
    localparam int CT_RX_THRESH = 8;
    localparam int CT_TX_THRESH = 16;

    typedef struct packed {
        logic [7:0] tx_thresh;
        logic [7:0] rx_thresh;
        logic       tx_irq_en;
        logic       rx_irq_en;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{tx_thresh: 8'd0, rx_thresh: 8'd1,
                                     tx_irq_en: 1'b0, rx_irq_en: 1'b0};

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with flush, count, full and empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [7:0]       count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_MAX);
    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = 8'(count_q);

endmodule

// File: rtl/cdc_fifo_mmio.sv
// rtl/cdc_fifo_mmio.sv - 32-bit register front end for TX/RX byte FIFOs toward USB_CDC
module cdc_fifo_mmio
    import cdc_fifo_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        sel_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        rx_irq_o,
    output logic        tx_irq_o,
    output logic [7:0]  in_data_o,
    output logic        in_valid_o,
    input  logic        in_ready_i,
    input  logic [7:0]  out_data_i,
    input  logic        out_valid_i,
    output logic        out_ready_o
);

    ctrl_t       ctrl_q, ctrl_d;
    logic        tx_drop_q, tx_drop_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rx_irq_q, rx_irq_d;
    logic        tx_irq_q, tx_irq_d;

    logic        wr_en, rd_en;
    logic        tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [7:0]  tx_count, rx_count, rx_rdata, rx_thresh_eff;
    logic        unused_data;

    assign unused_data = ^data_i[31:24];

    // Read together with write is treated as a write only.
    assign wr_en = sel_i && write_i;
    assign rd_en = sel_i && read_i && !write_i;

    assign tx_push  = wr_en && (addr_i == REG_DATA);
    assign tx_pop   = in_valid_o && in_ready_i;
    assign tx_flush = wr_en && (addr_i == REG_CTRL) && data_i[CT_TX_FLUSH];
    assign rx_push  = out_valid_i && out_ready_o;
    assign rx_pop   = rd_en && (addr_i == REG_DATA) && !rx_empty;
    assign rx_flush = wr_en && (addr_i == REG_CTRL) && data_i[CT_RX_FLUSH];

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (tx_push),
        .wdata_i (data_i[7:0]),
        .pop_i   (tx_pop),
        .flush_i (tx_flush),
        .rdata_o (in_data_o),
        .count_o (tx_count),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (rx_push),
        .wdata_i (out_data_i),
        .pop_i   (rx_pop),
        .flush_i (rx_flush),
        .rdata_o (rx_rdata),
        .count_o (rx_count),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign in_valid_o  = !tx_empty;
    assign out_ready_o = !rx_full;

    always_comb begin
        ctrl_d    = ctrl_q;
        tx_drop_d = tx_drop_q;
        if (wr_en && (addr_i == REG_CTRL)) begin
            ctrl_d.rx_irq_en = data_i[CT_RX_IRQ_EN];
            ctrl_d.tx_irq_en = data_i[CT_TX_IRQ_EN];
            ctrl_d.rx_thresh = data_i[CT_RX_THRESH +: 8];
            ctrl_d.tx_thresh = data_i[CT_TX_THRESH +: 8];
        end
        if (wr_en && (addr_i == REG_STATUS) && data_i[ST_TX_DROP]) tx_drop_d = 1'b0;
        if (tx_push && tx_full && !tx_pop) tx_drop_d = 1'b1;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            case (addr_i)
                REG_DATA: begin
                    if (!rx_empty) begin
                        rdata_d[7:0]           = rx_rdata;
                        rdata_d[DATA_VALID_BIT] = 1'b1;
                    end
                end
                REG_STATUS: begin
                    rdata_d[ST_RX_EMPTY]     = rx_empty;
                    rdata_d[ST_RX_FULL]      = rx_full;
                    rdata_d[ST_TX_EMPTY]     = tx_empty;
                    rdata_d[ST_TX_FULL]      = tx_full;
                    rdata_d[ST_TX_DROP]      = tx_drop_q;
                    rdata_d[ST_RX_CNT +: 8]  = rx_count;
                    rdata_d[ST_TX_CNT +: 8]  = tx_count;
                end
                REG_CTRL: begin
                    rdata_d[CT_RX_IRQ_EN]     = ctrl_q.rx_irq_en;
                    rdata_d[CT_TX_IRQ_EN]     = ctrl_q.tx_irq_en;
                    rdata_d[CT_RX_THRESH +: 8] = ctrl_q.rx_thresh;
                    rdata_d[CT_TX_THRESH +: 8] = ctrl_q.tx_thresh;
                end
                default: rdata_d = '0;
            endcase
        end
    end

    // A zero RX threshold behaves as one so the IRQ never fires on an empty FIFO.
    assign rx_thresh_eff = (ctrl_q.rx_thresh == 8'd0) ? 8'd1 : ctrl_q.rx_thresh;

    always_comb begin
        rx_irq_d = ctrl_q.rx_irq_en && (rx_count >= rx_thresh_eff);
        tx_irq_d = ctrl_q.tx_irq_en && (tx_count <= ctrl_q.tx_thresh);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ctrl_q    <= CTRL_RESET;
            tx_drop_q <= 1'b0;
            rdata_q   <= '0;
            rx_irq_q  <= 1'b0;
            tx_irq_q  <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            tx_drop_q <= tx_drop_d;
            rdata_q   <= rdata_d;
            rx_irq_q  <= rx_irq_d;
            tx_irq_q  <= tx_irq_d;
        end
    end

    assign data_o   = rdata_q;
    assign rx_irq_o = rx_irq_q;
    assign tx_irq_o = tx_irq_q;

endmodule

// File: tb/tb_cdc_fifo_mmio.sv
// tb/tb_cdc_fifo_mmio.sv - directed self-checking bench for cdc_fifo_mmio
module tb_cdc_fifo_mmio;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sel, rd, wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rx_irq, tx_irq;
    logic [7:0]  in_data;
    logic        in_valid, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_ready;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cdc_fifo_mmio #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .sel_i       (sel),
        .read_i      (rd),
        .write_i     (wr),
        .addr_i      (addr),
        .data_i      (wdata),
        .data_o      (rdata),
        .rx_irq_o    (rx_irq),
        .tx_irq_o    (tx_irq),
        .in_data_o   (in_data),
        .in_valid_o  (in_valid),
        .in_ready_i  (in_ready),
        .out_data_i  (out_data),
        .out_valid_i (out_valid),
        .out_ready_o (out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; wr = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1; rd = 1'b1; addr = a;
        tick();
        sel = 1'b0; rd = 1'b0;
        d = rdata;
    endtask

    task automatic rx_send(input logic [7:0] b);
        out_valid = 1'b1; out_data = b;
        tick();
        out_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        total++; if ({rdata, rx_irq, tx_irq, in_valid, out_ready} !== {32'h0, 4'b0001})
            $display("FAIL reset_outputs got %h/%b%b%b%b", rdata, rx_irq, tx_irq, in_valid, out_ready);
        else passed++;
        bus_read(2'd1, r);
        total++; if (r !== 32'h0000_0005) $display("FAIL reset_status got %h want 00000005", r); else passed++;
        bus_read(2'd2, r);
        total++; if (r !== 32'h0000_0100) $display("FAIL reset_ctrl got %h want 00000100", r); else passed++;
        bus_read(2'd3, r);
        total++; if (r !== 32'h0) $display("FAIL reserved_read got %h want 0", r); else passed++;
    endtask

    task automatic test_tx_path();
        logic [31:0] r;
        logic [7:0] exp_b [3] = '{8'h41, 8'h42, 8'h43};
        in_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(2'd0, {24'h0, exp_b[i]});
        bus_read(2'd1, r);
        total++; if (r !== 32'h0003_0001) $display("FAIL tx_status got %h want 00030001", r); else passed++;
        in_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if ({in_valid, in_data} !== {1'b1, exp_b[i]})
                $display("FAIL tx_stream%0d got %b/%h want 1/%h", i, in_valid, in_data, exp_b[i]);
            else passed++;
            tick();
        end
        total++; if (in_valid !== 1'b0) $display("FAIL tx_drained got %b want 0", in_valid); else passed++;
        in_ready = 1'b0;
    endtask

    task automatic test_rx_path();
        logic [31:0] r;
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (out_ready !== 1'b1) bad++;
            rx_send(8'(i));
        end
        total++; if (bad != 0) $display("FAIL rx_ready_early got %0d stalls want 0", bad); else passed++;
        total++; if (out_ready !== 1'b0) $display("FAIL rx_full_ready got %b want 0", out_ready); else passed++;
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, r);
            total++; if (r !== 32'h100 + 32'(i)) $display("FAIL rx_read%0d got %h want %h", i, r, 32'h100 + 32'(i));
            else passed++;
        end
        bus_read(2'd0, r);
        total++; if (r !== 32'h0) $display("FAIL rx_empty_read got %h want 0", r); else passed++;
    endtask

    task automatic test_tx_full();
        logic [31:0] r;
        in_ready = 1'b0;
        for (int i = 0; i < 16; i++) bus_write(2'd0, 32'h10 + 32'(i));
        bus_read(2'd1, r);
        total++; if (r !== 32'h0010_0009) $display("FAIL tx_full_status got %h want 00100009", r); else passed++;
        bus_write(2'd0, 32'hEE);
        bus_read(2'd1, r);
        total++; if (r !== 32'h0010_0019) $display("FAIL tx_drop_set got %h want 00100019", r); else passed++;
        bus_write(2'd1, 32'h10);
        bus_read(2'd1, r);
        total++; if (r !== 32'h0010_0009) $display("FAIL tx_drop_clear got %h want 00100009", r); else passed++;
    endtask

    task automatic test_full_pop_push();
        logic [31:0] r;
        int bad = 0;
        in_ready = 1'b1;
        bus_write(2'd0, 32'h77);
        in_ready = 1'b0;
        bus_read(2'd1, r);
        total++; if (r !== 32'h0010_0009) $display("FAIL poppush_status got %h want 00100009", r); else passed++;
        in_ready = 1'b1;
        for (int i = 1; i < 17; i++) begin
            logic [7:0] e;
            e = (i == 16) ? 8'h77 : 8'(8'h10 + i);
            if ({in_valid, in_data} !== {1'b1, e}) bad++;
            tick();
        end
        total++; if (bad != 0) $display("FAIL popush_order got %0d wrong bytes want 0", bad); else passed++;
        total++; if (in_valid !== 1'b0) $display("FAIL popush_drained got %b want 0", in_valid); else passed++;
        in_ready = 1'b0;
    endtask

    task automatic test_irq();
        logic [31:0] r;
        bus_write(2'd2, 32'h0000_0401);
        for (int i = 0; i < 4; i++) rx_send(8'hA0 + 8'(i));
        total++; if (rx_irq !== 1'b0) $display("FAIL rx_irq_early got %b want 0", rx_irq); else passed++;
        tick();
        total++; if (rx_irq !== 1'b1) $display("FAIL rx_irq_rise got %b want 1", rx_irq); else passed++;
        bus_read(2'd0, r);
        total++; if (r !== 32'h1A0) $display("FAIL rx_irq_data got %h want 000001a0", r); else passed++;
        tick();
        total++; if (rx_irq !== 1'b0) $display("FAIL rx_irq_fall got %b want 0", rx_irq); else passed++;
        bus_write(2'd2, 32'h0000_0002);
        tick();
        total++; if (tx_irq !== 1'b1) $display("FAIL tx_irq_empty got %b want 1", tx_irq); else passed++;
        bus_write(2'd0, 32'h55);
        tick();
        total++; if (tx_irq !== 1'b0) $display("FAIL tx_irq_nonempty got %b want 0", tx_irq); else passed++;
        for (int i = 1; i < 4; i++) bus_read(2'd0, r);
        total++; if (r !== 32'h1A3) $display("FAIL rx_drain got %h want 000001a3", r); else passed++;
    endtask

    task automatic test_flush_reset();
        logic [31:0] r;
        int bad = 0;
        bus_write(2'd0, 32'h56);
        bus_write(2'd0, 32'h57);
        in_ready = 1'b1;
        bus_write(2'd2, 32'h0000_0008);
        for (int i = 0; i < 3; i++) begin
            if (in_valid !== 1'b0) bad++;
            tick();
        end
        total++; if (bad != 0) $display("FAIL flush_emit got %0d valid cycles want 0", bad); else passed++;
        in_ready = 1'b0;
        bus_read(2'd1, r);
        total++; if (r !== 32'h0000_0005) $display("FAIL flush_status got %h want 00000005", r); else passed++;

        bus_write(2'd0, 32'h61);
        bus_write(2'd0, 32'h62);
        rx_send(8'h71);
        rx_send(8'h72);
        bus_write(2'd2, 32'h00FF_0003);
        tick();
        total++; if ({rx_irq, tx_irq} !== 2'b11) $display("FAIL irq_hi_thresh got %b%b want 11", rx_irq, tx_irq);
        else passed++;
        bus_read(2'd2, r);
        total++; if (r !== 32'h00FF_0003) $display("FAIL ctrl_readback got %h want 00ff0003", r); else passed++;
        in_ready = 1'b1;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        total++; if ({rdata, rx_irq, tx_irq, in_valid, out_ready} !== {32'h0, 4'b0001})
            $display("FAIL midreset_outputs got %h/%b%b%b%b", rdata, rx_irq, tx_irq, in_valid, out_ready);
        else passed++;
        in_ready = 1'b0;
        bus_read(2'd1, r);
        total++; if (r !== 32'h0000_0005) $display("FAIL midreset_status got %h want 00000005", r); else passed++;
        bus_read(2'd2, r);
        total++; if (r !== 32'h0000_0100) $display("FAIL midreset_ctrl got %h want 00000100", r); else passed++;
    endtask

    initial begin
        rstn = 1'b0; sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        in_ready = 1'b0; out_data = '0; out_valid = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        test_reset();
        test_tx_path();
        test_rx_path();
        test_tx_full();
        test_full_pop_push();
        test_irq();
        test_flush_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
